// File: rtl/temporizador_regressivo_if.sv
// Control/status bundle for the countdown timer (temporizador_regressivo).
// The master drives the commands (zera_s, carrega, valor, conta) and observes
// the count and flags; the slave is the timer itself.
interface temporizador_regressivo_if #(
  parameter int N = 13
);
  logic         zera_s;
  logic         carrega;
  logic [N-1:0] valor;
  logic         conta;
  logic [N-1:0] Q;
  logic         fim;
  logic         zero;
  logic         meio;
  logic [1:0]   db_estado;

  modport master (
    output zera_s, carrega, valor, conta,
    input  Q, fim, zero, meio, db_estado
  );

  modport slave (
    input  zera_s, carrega, valor, conta,
    output Q, fim, zero, meio, db_estado
  );
endinterface

// File: rtl/temporizador_regressivo.sv
// Loadable countdown timer: loads a duration (saturated to M-1), decrements while
// conta is high, flags the halfway point and pulses fim for one cycle at zero.
// Optional macro AUTO_RECARGA_EN turns it into a periodic timer (reload on expiry).
module temporizador_regressivo #(
  parameter int M = 5000,
  parameter int N = 13   // 2^N must be >= M
) (
  input logic                      clock,
  input logic                      zera_as,
  temporizador_regressivo_if.slave bus
);

  localparam logic [1:0] OCIOSO    = 2'b00;
  localparam logic [1:0] CONTANDO  = 2'b01;
  localparam logic [1:0] PAUSADO   = 2'b10;
  localparam logic [1:0] TERMINADO = 2'b11;

  localparam logic [N-1:0] MAX_V = N'(M - 1);
  localparam logic [N-1:0] ONE   = N'(1);

  logic [N-1:0] q, q_n;
  logic [N-1:0] carregado, carregado_n;
  logic [1:0]   estado, estado_n;
  logic         fim_r, fim_n;
  logic [N-1:0] v_sat;

  // Loaded value clipped to the longest supported duration.
  assign v_sat = (bus.valor > MAX_V) ? MAX_V : bus.valor;

  // Next-state logic: zera_s beats carrega, which beats conta.
  always_comb begin
    q_n         = q;
    carregado_n = carregado;
    estado_n    = estado;
    fim_n       = 1'b0;
    if (bus.zera_s) begin
      q_n         = '0;
      carregado_n = '0;
      estado_n    = OCIOSO;
    end else if (bus.carrega) begin
      // A load always restarts; a zero duration finishes silently (no fim).
      q_n         = v_sat;
      carregado_n = v_sat;
      estado_n    = (v_sat == '0) ? TERMINADO : PAUSADO;
    end else begin
      case (estado)
        CONTANDO, PAUSADO: begin
          if (bus.conta) begin
            // q <= 1 (rather than == 1) keeps the counter from ever wrapping.
            if (q <= ONE) begin
`ifdef AUTO_RECARGA_EN
              q_n      = carregado;
              estado_n = CONTANDO;
`else
              q_n      = '0;
              estado_n = TERMINADO;
`endif
              fim_n    = 1'b1;
            end else begin
              q_n      = q - ONE;
              estado_n = CONTANDO;
            end
          end else begin
            estado_n = PAUSADO;
          end
        end
        default: begin
          // OCIOSO and TERMINADO hold their value and ignore conta.
        end
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      q         <= '0;
      carregado <= '0;
      estado    <= OCIOSO;
      fim_r     <= 1'b0;
    end else begin
      q         <= q_n;
      carregado <= carregado_n;
      estado    <= estado_n;
      fim_r     <= fim_n;
    end
  end

  assign bus.Q         = q;
  assign bus.fim       = fim_r;
  assign bus.zero      = (q == '0);
  assign bus.meio      = ((estado == CONTANDO) || (estado == PAUSADO)) &&
                         (q == (carregado >> 1));
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Self-checking bench for temporizador_regressivo: directed scenarios plus random
// stimulus, all compared against a behavioural model of the countdown rules.
module tb_temporizador_regressivo;

  localparam int M = 5000;
  localparam int N = 13;

  logic clock = 1'b0;
  logic zera_as = 1'b1;
  int   total = 0;
  int   bad   = 0;

  temporizador_regressivo_if #(.N(N)) bus_if ();

  temporizador_regressivo #(.M(M), .N(N)) dut (
    .clock  (clock),
    .zera_as(zera_as),
    .bus    (bus_if)
  );

  always #5 clock = ~clock;

  // Behavioural model: remaining count, loaded duration and a few phase flags.
  int m_q, m_load;
  bit m_armed, m_run, m_done, m_fim;

  task automatic model_reset();
    m_q = 0; m_load = 0; m_armed = 0; m_run = 0; m_done = 0; m_fim = 0;
  endtask

  task automatic model_edge();
    int v;
    m_fim = 0;
    if (bus_if.zera_s) begin
      model_reset();
    end else if (bus_if.carrega) begin
      v = (int'(bus_if.valor) > M - 1) ? M - 1 : int'(bus_if.valor);
      m_q = v; m_load = v; m_run = 0;
      m_armed = (v != 0);
      m_done  = (v == 0);
    end else if (m_armed) begin
      if (bus_if.conta) begin
        m_run = 1;
        if (m_q > 1) m_q = m_q - 1;
        else begin
          m_fim = 1;
`ifdef AUTO_RECARGA_EN
          m_q = m_load;
`else
          m_q = 0; m_armed = 0; m_done = 1;
`endif
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  function automatic logic [N+4:0] exp_vec();
    logic [1:0] st;
    logic       mid;
    st  = m_done ? 2'd3 : (m_armed ? (m_run ? 2'd1 : 2'd2) : 2'd0);
    mid = m_armed && (m_q == m_load / 2);
    return {N'(m_q), m_fim, (m_q == 0), mid, st};
  endfunction

  function automatic logic [N+4:0] obs_vec();
    return {bus_if.Q, bus_if.fim, bus_if.zero, bus_if.meio, bus_if.db_estado};
  endfunction

  task automatic set_in(input bit zs, input bit ld, input int v, input bit ct);
    bus_if.zera_s  = zs;
    bus_if.carrega = ld;
    bus_if.valor   = N'(v);
    bus_if.conta   = ct;
  endtask

  // Advance one edge, update the model, then settle away from the edge.
  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0);
    model_reset();
    #2;
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_state obs=%h exp=%h", obs_vec(), exp_vec());
    end
    @(negedge clock); zera_as = 1'b0;
    set_in(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec() || bus_if.fim !== 1'b0 || bus_if.Q !== '0) begin
        bad++; $display("FAIL idle cyc=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_one_shot();
    int fim_at, fim_n, meio_n;
    fim_at = -1; fim_n = 0; meio_n = 0;
    set_in(0, 1, 20, 1);
    tick();
    set_in(0, 0, 0, 1);
    for (int k = 1; k <= 25; k++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL one_shot k=%0d obs=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (bus_if.fim) begin
        fim_n++; fim_at = k;
        total++;
        if (bus_if.Q !== '0 || bus_if.db_estado !== 2'b11) begin
          bad++; $display("FAIL one_shot_fim_state q=%0d st=%b need q=0 st=11", bus_if.Q, bus_if.db_estado);
        end
      end
      if (bus_if.meio) begin
        meio_n++;
        total++;
        if (bus_if.Q !== 13'd10) begin
          bad++; $display("FAIL one_shot_meio q=%0d need 10", bus_if.Q);
        end
      end
    end
`ifndef AUTO_RECARGA_EN
    total++;
    if (fim_n != 1 || fim_at != 20 || meio_n != 1) begin
      bad++; $display("FAIL one_shot_timing fims=%0d at=%0d meios=%0d need 1/20/1", fim_n, fim_at, meio_n);
    end
`endif
  endtask

  task automatic test_pause();
    int counted, fim_at;
    counted = 0; fim_at = -1;
    set_in(0, 1, 30, 0);
    tick();
    for (int k = 0; k < 50; k++) begin
      set_in(0, 0, 0, (k < 10 || k >= 15));
      tick();
      if (bus_if.conta) counted++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL pause k=%0d obs=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (k >= 10 && k < 15) begin
        total++;
        if (bus_if.Q !== 13'd20 || bus_if.db_estado !== 2'b10) begin
          bad++; $display("FAIL pause_hold q=%0d st=%b need 20/10", bus_if.Q, bus_if.db_estado);
        end
      end
      if (bus_if.fim && fim_at < 0) fim_at = counted;
    end
    total++;
    if (fim_at != 30) begin
      bad++; $display("FAIL pause_fim at=%0d need 30", fim_at);
    end
  endtask

  task automatic test_saturation();
    int fim_at, meio_at;
    fim_at = -1; meio_at = -1;
    set_in(0, 1, 6000, 1);
    tick();
    total++;
    if (bus_if.Q !== 13'd4999 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL sat_load q=%0d need 4999", bus_if.Q);
    end
    set_in(0, 0, 0, 1);
    for (int k = 1; k <= 5010; k++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL sat k=%0d obs=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (bus_if.meio && meio_at < 0) meio_at = int'(bus_if.Q);
      if (bus_if.fim && fim_at < 0) fim_at = k;
    end
    total++;
    if (meio_at != 2499 || fim_at != 4999) begin
      bad++; $display("FAIL sat_timing meio_q=%0d fim_at=%0d need 2499/4999", meio_at, fim_at);
    end
  endtask

  task automatic test_priority();
    set_in(0, 1, 12, 1);
    tick();
    set_in(0, 0, 0, 1);
    repeat (3) tick();
    set_in(1, 1, 7, 1);
    tick();
    total++;
    if (bus_if.Q !== '0 || bus_if.db_estado !== 2'b00 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL prio_clear q=%0d st=%b need 0/00", bus_if.Q, bus_if.db_estado);
    end
    set_in(0, 1, 15, 1);
    tick();
    set_in(0, 0, 0, 1);
    repeat (4) tick();
    #3 zera_as = 1'b1;
    #1;
    model_reset();
    total++;
    if (bus_if.Q !== '0 || bus_if.fim !== 1'b0 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL async_clear obs=%h exp=%h", obs_vec(), exp_vec());
    end
    #1 zera_as = 1'b0;
    repeat (3) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL after_async obs=%h exp=%h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, 40));
      set_in($urandom_range(0, 49) == 0, $urandom_range(0, 14) == 0, v, $urandom_range(0, 3) != 0);
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random i=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

`ifdef AUTO_RECARGA_EN
  task automatic test_auto_reload();
    int fims[$];
    set_in(0, 1, 5, 1);
    tick();
    set_in(0, 0, 0, 1);
    for (int k = 1; k <= 22; k++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec() || bus_if.db_estado !== 2'b01 || bus_if.zero !== 1'b0) begin
        bad++; $display("FAIL auto k=%0d obs=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (bus_if.fim) fims.push_back(k);
    end
    total++;
    if (fims.size() != 4 || fims[0] != 5 || fims[1] != 10 || fims[2] != 15 || fims[3] != 20) begin
      bad++; $display("FAIL auto_period fims=%0d need 4 at 5,10,15,20", fims.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_one_shot();
    test_pause();
    test_saturation();
    test_priority();
`ifdef AUTO_RECARGA_EN
    test_auto_reload();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
